// File: rtl/piso_if.sv
// Load and serial-side signals of the PISO serializer.
// The master drives the word and the downstream ready. The slave (piso) drives the rest.
interface piso_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] par_in;
    logic             par_valid;
    logic             par_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             serial_ready;
    logic             busy;
    logic             frame_done;

    modport master (
        output par_in, par_valid, serial_ready,
        input  par_ready, serial_out, serial_valid, busy, frame_done
    );

    modport slave (
        input  par_in, par_valid, serial_ready,
        output par_ready, serial_out, serial_valid, busy, frame_done
    );
endinterface

// File: rtl/piso.sv
// Parallel-in serial-out shift register with a valid/ready load handshake.
// A new word can load on the same edge as the last bit of the current word.
// This allows back-to-back frames with no idle cycle between them.
module piso #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic  clk,
    input  logic  rst_n,
    piso_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             frame_done;
    logic             xfer, last, ready, load;

    // Move the next bit to the output end of the register and fill the vacated end with 0.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        if (MSB_FIRST)
            shift_one = {v[WIDTH-2:0], 1'b0};
        else
            shift_one = {1'b0, v[WIDTH-1:1]};
    endfunction

    // Handshake decode and next-state selection; a load takes priority over the end of a frame.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        xfer      = (state == SHIFT) && bus.serial_ready;
        last      = xfer && (cnt == CNT_LAST);
        ready     = (state == IDLE) || last;
        load      = bus.par_valid && ready;
        if (load) begin
            shreg_nxt = bus.par_in;
            cnt_nxt   = '0;
            state_nxt = SHIFT;
        end else if (last) begin
            shreg_nxt = shift_one(shreg);
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end else if (xfer) begin
            shreg_nxt = shift_one(shreg);
            cnt_nxt   = cnt + 1'b1;
        end
    end

    // State, shift register and counter update; frame_done marks the edge that sent the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            cnt        <= cnt_nxt;
            frame_done <= last;
        end
    end

    // serial_out comes straight from a register bit, so no input reaches it combinationally.
    assign bus.serial_out   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign bus.serial_valid = (state == SHIFT);
    assign bus.busy         = (state == SHIFT);
    assign bus.par_ready    = ready;
    assign bus.frame_done   = frame_done;
endmodule
